// File: rtl/spi_slave_word_if.sv
// SPI slave with clk-domain oversampling, all four CPOL/CPHA modes and multi-byte burst words.
// A single holding register buffers the next TX word; underrun and frame-error flags pulse.
module spi_slave_word_if #(
    parameter int unsigned WORD_BYTES  = 4,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned MSB_FIRST   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      sck_i,
    input  logic                      mosi_i,
    output logic                      miso_o,
    input  logic                      ssel_i,
    output logic [8*WORD_BYTES-1:0]   rx_word_o,
    output logic                      rx_valid_o,
    input  logic [8*WORD_BYTES-1:0]   tx_word_i,
    input  logic                      tx_load_i,
    output logic                      tx_ready_o,
    output logic                      tx_underrun_o,
    output logic                      frame_err_o,
    output logic                      busy_o
);

    localparam int unsigned W       = 8 * WORD_BYTES;
    localparam int unsigned CW      = $clog2(W);
    localparam logic        SckIdle = (CPOL != 0);
    localparam logic        Cpha1   = (CPHA != 0);
    localparam logic        MsbFst  = (MSB_FIRST != 0);

    typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ssel_sync_q;
    logic                   sck_new, sck_old, mosi_s, ssel_s;
    logic                   rise, fall, sample_e, shift_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic [W-1:0]  rx_word_q, rx_word_d, hold_q, hold_d;
    logic [W-1:0]  rx_next, tx_next, word_ld;
    logic          miso_q, miso_d, rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
    logic          und_pend_q, und_pend_d, underrun_q, underrun_d, frame_err_q, frame_err_d;

    function automatic logic first_bit(input logic [W-1:0] x);
        return MsbFst ? x[W-1] : x[0];
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_q  <= {SYNC_STAGES{SckIdle}};
            mosi_sync_q <= '0;
            ssel_sync_q <= '1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-2:0], ssel_i};
        end
    end

    assign sck_new  = sck_sync_q[SYNC_STAGES-2];
    assign sck_old  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign ssel_s   = ssel_sync_q[SYNC_STAGES-1];
    assign rise     = sck_new & ~sck_old;
    assign fall     = ~sck_new & sck_old;
    assign sample_e = (Cpha1 ^ SckIdle) ? fall : rise;
    assign shift_e  = (Cpha1 ^ SckIdle) ? rise : fall;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_word_d   = rx_word_q;
        hold_d      = hold_q;
        miso_d      = miso_q;
        tx_ready_d  = tx_ready_q;
        und_pend_d  = und_pend_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;
        rx_next     = MsbFst ? {rx_shift_q[W-2:0], mosi_s} : {mosi_s, rx_shift_q[W-1:1]};
        tx_next     = MsbFst ? {tx_shift_q[W-2:0], 1'b0} : {1'b0, tx_shift_q[W-1:1]};
        word_ld     = tx_ready_q ? '0 : hold_q;

        if (tx_load_i && tx_ready_q) begin
            hold_d     = tx_word_i;
            tx_ready_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d      = '0;
                miso_d     = 1'b0;
                und_pend_d = 1'b0;
                if (!ssel_s) state_d = StLoad;
            end
            StLoad: begin
                tx_shift_d = word_ld;
                und_pend_d = tx_ready_q;
                if (!tx_ready_q) tx_ready_d = 1'b1;
                if (!Cpha1) miso_d = first_bit(word_ld);
                state_d = StShift;
            end
            StShift: begin
                if (ssel_s) begin
                    frame_err_d = (cnt_q != '0);
                    cnt_d       = '0;
                    miso_d      = 1'b0;
                    und_pend_d  = 1'b0;
                    state_d     = StIdle;
                end else begin
                    if (sample_e) begin
                        rx_shift_d = rx_next;
                        // Underrun is reported when the word actually starts clocking, so the
                        // speculative LOAD after a frame's last word stays silent.
                        if (cnt_q == '0 && und_pend_q) begin
                            underrun_d = 1'b1;
                            und_pend_d = 1'b0;
                        end
                        if (cnt_q == CW'(W - 1)) begin
                            rx_word_d  = rx_next;
                            rx_valid_d = 1'b1;
                            cnt_d      = '0;
                            state_d    = StLoad;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    // Shift edges at count 0 never advance: bit 0 is already on the line
                    // (CPHA=0) or is presented here for the first time (CPHA=1).
                    if (shift_e) begin
                        if (cnt_q != '0) begin
                            tx_shift_d = tx_next;
                            miso_d     = first_bit(tx_next);
                        end else if (Cpha1) begin
                            miso_d = first_bit(tx_shift_q);
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_word_q   <= '0;
            hold_q      <= '0;
            miso_q      <= 1'b0;
            tx_ready_q  <= 1'b1;
            und_pend_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_word_q   <= rx_word_d;
            hold_q      <= hold_d;
            miso_q      <= miso_d;
            tx_ready_q  <= tx_ready_d;
            und_pend_q  <= und_pend_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso_o        = miso_q;
    assign rx_word_o     = rx_word_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_ready_o    = tx_ready_q;
    assign tx_underrun_o = underrun_q;
    assign frame_err_o   = frame_err_q;
    assign busy_o        = ~ssel_s;

endmodule

// File: tb/tb_spi_slave_word_if.sv
// Bench for spi_slave_word_if: one 32-bit mode-0 slave plus five 8-bit slaves covering the
// four SPI modes and LSB-first order; received words are checked by a scoreboard monitor.
module tb_spi_slave_word_if;

    localparam int HALF = 60;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] w;
    } exp_t;

    logic        clk, rst_n, mosi;
    logic        sck_a [6];
    logic        ssel_a [6];
    logic        miso_a [6];
    logic        rxv_a [6];
    logic        txl_a [6];
    logic        txr_a [6];
    logic        und_a [6];
    logic        ferr_a [6];
    logic        busy_a [6];
    logic [31:0] rxw [6];
    logic [31:0] txw_a [6];

    int   checks, errors;
    int   und_cnt [6];
    int   ferr_cnt [6];
    exp_t exp_q [$];
    exp_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_slave_word_if #(
        .WORD_BYTES (4),
        .CPOL       (0),
        .CPHA       (0),
        .MSB_FIRST  (1),
        .SYNC_STAGES(3)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sck_i        (sck_a[0]),
        .mosi_i       (mosi),
        .miso_o       (miso_a[0]),
        .ssel_i       (ssel_a[0]),
        .rx_word_o    (rxw[0]),
        .rx_valid_o   (rxv_a[0]),
        .tx_word_i    (txw_a[0]),
        .tx_load_i    (txl_a[0]),
        .tx_ready_o   (txr_a[0]),
        .tx_underrun_o(und_a[0]),
        .frame_err_o  (ferr_a[0]),
        .busy_o       (busy_a[0])
    );

    for (genvar g = 1; g < 6; g++) begin : g_small
        logic [7:0] rx8;
        spi_slave_word_if #(
            .WORD_BYTES (1),
            .CPOL       ((g == 3 || g == 4) ? 1 : 0),
            .CPHA       ((g == 2 || g == 4) ? 1 : 0),
            .MSB_FIRST  ((g == 5) ? 0 : 1),
            .SYNC_STAGES(2)
        ) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .sck_i        (sck_a[g]),
            .mosi_i       (mosi),
            .miso_o       (miso_a[g]),
            .ssel_i       (ssel_a[g]),
            .rx_word_o    (rx8),
            .rx_valid_o   (rxv_a[g]),
            .tx_word_i    (txw_a[g][7:0]),
            .tx_load_i    (txl_a[g]),
            .tx_ready_o   (txr_a[g]),
            .tx_underrun_o(und_a[g]),
            .frame_err_o  (ferr_a[g]),
            .busy_o       (busy_a[g])
        );
        assign rxw[g] = {24'h0, rx8};
    end

    function automatic bit cpol_of(input int i);
        return (i == 3 || i == 4);
    endfunction

    function automatic bit cpha_of(input int i);
        return (i == 2 || i == 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rx_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (rxv_a[i] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: inst %0d got %h, expected no word", i, rxw[i]);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rx_inst", i, mon_e.idx);
                    check("rx_word", rxw[i], mon_e.w);
                end
            end
            if (und_a[i] === 1'b1) und_cnt[i]++;
            if (ferr_a[i] === 1'b1) ferr_cnt[i]++;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input int idx, input logic [31:0] w);
        exp_q.push_back('{idx: idx, w: w});
    endtask

    task automatic load(input int idx, input logic [31:0] w);
        int n = 0;
        while (txr_a[idx] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_before_load", {31'h0, txr_a[idx]}, 32'h1);
        @(negedge clk);
        txw_a[idx] = w;
        txl_a[idx] = 1'b1;
        @(negedge clk);
        txl_a[idx] = 1'b0;
    endtask

    task automatic frame_start(input int idx);
        @(negedge clk);
        ssel_a[idx] = 1'b0;
        #(2 * HALF);
    endtask

    task automatic frame_end(input int idx);
        #HALF;
        ssel_a[idx] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Master side of one word: drives MOSI and captures MISO on the mode's sample edge.
    task automatic xfer(input int idx, input int nbits, input logic [31:0] dout,
                        output logic [31:0] din);
        bit cpol = cpol_of(idx);
        bit cpha = cpha_of(idx);
        din = '0;
        for (int i = 0; i < nbits; i++) begin
            int b = (idx == 5) ? i : nbits - 1 - i;
            if (!cpha) begin
                mosi = dout[b];
                #HALF;
                sck_a[idx] = ~cpol;
                din[b] = miso_a[idx];
                #HALF;
                sck_a[idx] = cpol;
            end else begin
                sck_a[idx] = ~cpol;
                mosi = dout[b];
                #HALF;
                sck_a[idx] = cpol;
                din[b] = miso_a[idx];
                #HALF;
            end
        end
    endtask

    logic [31:0] cap;
    logic [31:0] burst_rx [3];
    logic [31:0] burst_tx [3];

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        mosi   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sck_a[i]    = cpol_of(i);
            ssel_a[i]   = 1'b1;
            txl_a[i]    = 1'b0;
            txw_a[i]    = '0;
            und_cnt[i]  = 0;
            ferr_cnt[i] = 0;
        end
        repeat (4) @(negedge clk);
        check("reset_outputs", {rxw[0][7:0], rxv_a[0], miso_a[0], txr_a[0], und_a[0],
                                ferr_a[0], busy_a[0]}, {8'h00, 6'b001000});
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0, 32-bit word.
        load(0, 32'hCAFEF00D);
        check("tx_ready_after_load", {31'h0, txr_a[0]}, 32'h0);
        push_exp(0, 32'h12345678);
        frame_start(0);
        check("busy_in_frame", {31'h0, busy_a[0]}, 32'h1);
        check("tx_ready_after_LOAD", {31'h0, txr_a[0]}, 32'h1);
        xfer(0, 32, 32'h12345678, cap);
        check("miso_mode0_w32", cap, 32'hCAFEF00D);
        frame_end(0);
        check("busy_after_frame", {31'h0, busy_a[0]}, 32'h0);

        // All four modes, 8-bit words.
        for (int g = 1; g <= 4; g++) begin
            load(g, 32'h3C);
            push_exp(g, 32'hA5);
            frame_start(g);
            xfer(g, 8, 32'hA5, cap);
            check("miso_mode_w8", cap, 32'h3C);
            frame_end(g);
        end

        // Burst of three words with reload after each LOAD.
        burst_rx = '{32'hA1B2C3D4, 32'h55667788, 32'h99AABBCC};
        burst_tx = '{32'hF0E1D2C3, 32'h0F1E2D3C, 32'h89ABCDEF};
        load(0, burst_tx[0]);
        for (int k = 0; k < 3; k++) push_exp(0, burst_rx[k]);
        frame_start(0);
        load(0, burst_tx[1]);
        for (int k = 0; k < 3; k++) begin
            xfer(0, 32, burst_rx[k], cap);
            check("miso_burst", cap, burst_tx[k]);
            if (k == 0) load(0, burst_tx[2]);
        end
        frame_end(0);
        check("no_underrun_burst", und_cnt[0], 0);

        // Burst with the third reload omitted.
        burst_rx = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
        burst_tx = '{32'h13579BDF, 32'h2468ACE0, 32'h00000000};
        load(0, burst_tx[0]);
        for (int k = 0; k < 3; k++) push_exp(0, burst_rx[k]);
        frame_start(0);
        load(0, burst_tx[1]);
        for (int k = 0; k < 3; k++) begin
            xfer(0, 32, burst_rx[k], cap);
            check("miso_burst_underrun", cap, burst_tx[k]);
        end
        frame_end(0);
        check("underrun_count", und_cnt[0], 1);

        // Frame aborted after 13 bits.
        load(0, 32'h77777777);
        frame_start(0);
        xfer(0, 13, 32'h00001ABC, cap);
        frame_end(0);
        check("frame_err_count", ferr_cnt[0], 1);
        check("rx_word_held", rxw[0], 32'h090A0B0C);
        load(0, 32'h31415926);
        push_exp(0, 32'h0BADF00D);
        frame_start(0);
        xfer(0, 32, 32'h0BADF00D, cap);
        check("miso_after_ferr", cap, 32'h31415926);
        frame_end(0);

        // Asynchronous reset during bit 9.
        load(0, 32'h11111111);
        frame_start(0);
        load(0, 32'h22222222);
        xfer(0, 9, 32'h000001FF, cap);
        mosi = 1'b1;
        #HALF;
        sck_a[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("busy_before_reset", {31'h0, busy_a[0]}, 32'h1);
        check("tx_full_before_reset", {31'h0, txr_a[0]}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_rx_word", rxw[0], 32'h0);
        check("async_reset_flags", {28'h0, rxv_a[0], miso_a[0], und_a[0], ferr_a[0]}, 32'h0);
        check("async_reset_ready_busy", {30'h0, txr_a[0], busy_a[0]}, 32'h2);
        sck_a[0]  = 1'b0;
        ssel_a[0] = 1'b1;
        mosi      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        load(0, 32'h5A5AA5A5);
        push_exp(0, 32'hDEADBEEF);
        frame_start(0);
        xfer(0, 32, 32'hDEADBEEF, cap);
        check("miso_after_reset", cap, 32'h5A5AA5A5);
        frame_end(0);
        check("flags_after_reset", {und_cnt[0][15:0], ferr_cnt[0][15:0]}, {16'd1, 16'd1});

        // LSB-first slave.
        load(5, 32'h80);
        push_exp(5, 32'h01);
        frame_start(5);
        xfer(5, 8, 32'h01, cap);
        check("miso_lsb_first", cap, 32'h80);
        frame_end(5);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        for (int i = 1; i < 6; i++) begin
            check("small_flags", und_cnt[i] + ferr_cnt[i], 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
